// File: rtl/mult_exec_pipe.sv
// Pipelined RV32M/RV64M multiply unit feeding the CDB, with bubble-collapsing stall and flush.
// Optional performance counters are enabled by defining MULT_EXEC_PERF_EN.
module mult_exec_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [1:0]       i_op,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic             i_flush,
  output logic             o_cdb_valid,
  input  logic             i_cdb_grant,
  output logic [TAG_W-1:0] o_cdb_tag,
  output logic [XLEN-1:0]  o_cdb_result,
  output logic             o_cdb_branch,
`ifdef MULT_EXEC_PERF_EN
  output logic [31:0]      o_perf_ops,
  output logic [31:0]      o_perf_stall,
`endif
  output logic             o_busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Handshakes: an op transfers on i_issue_valid & o_issue_ready; a result
  // transfers on o_cdb_valid & i_cdb_grant. i_flush overrides both.
  logic [LATENCY-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [LATENCY];
  logic [1:0]         r_op   [LATENCY];
  logic [2*XLEN-1:0]  r_prod [LATENCY];

  logic [LATENCY-1:0] w_move;
  logic               w_accept;
  logic               w_a_signed;
  logic               w_b_signed;
  logic [2*XLEN-1:0]  w_a_ext;
  logic [2*XLEN-1:0]  w_b_ext;
  logic [2*XLEN-1:0]  w_prod;

  // Extending both operands to 2*XLEN makes one modular multiply exact for all modes.
  assign w_a_signed = (i_op == OP_MULH) | (i_op == OP_MULHSU);
  assign w_b_signed = (i_op == OP_MULH);
  assign w_a_ext    = {{XLEN{w_a_signed & i_rs1_data[XLEN-1]}}, i_rs1_data};
  assign w_b_ext    = {{XLEN{w_b_signed & i_rs2_data[XLEN-1]}}, i_rs2_data};
  assign w_prod     = w_a_ext * w_b_ext;

  // A stage frees up when it is empty or everything ahead of it drains.
  always_comb begin
    w_move = '0;
    w_move[LATENCY-1] = ~r_valid[LATENCY-1] | i_cdb_grant;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      w_move[k] = ~r_valid[k] | w_move[k+1];
    end
  end

  assign o_issue_ready = (~r_valid[0] | w_move[0]) & ~i_flush;
  assign w_accept      = i_issue_valid & o_issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tag[k]  <= '0;
        r_op[k]   <= '0;
        r_prod[k] <= '0;
      end
    end else begin
      if (w_move[0]) begin
        r_valid[0] <= w_accept;
        r_tag[0]   <= i_rd_tag;
        r_op[0]    <= i_op;
        r_prod[0]  <= w_prod;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_move[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_tag[k]   <= r_tag[k-1];
          r_op[k]    <= r_op[k-1];
          r_prod[k]  <= r_prod[k-1];
        end
      end
      if (i_flush) begin
        r_valid <= '0;
      end
    end
  end

  assign o_cdb_valid  = r_valid[LATENCY-1];
  assign o_cdb_tag    = o_cdb_valid ? r_tag[LATENCY-1] : '0;
  assign o_cdb_result = !o_cdb_valid ? '0 :
                        (r_op[LATENCY-1] == OP_MUL) ? r_prod[LATENCY-1][XLEN-1:0] :
                                                      r_prod[LATENCY-1][2*XLEN-1:XLEN];
  assign o_cdb_branch = 1'b0;
  assign o_busy       = |r_valid;

`ifdef MULT_EXEC_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if (o_cdb_valid & ~i_cdb_grant) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign o_perf_ops   = r_perf_ops;
  assign o_perf_stall = r_perf_stall;
`endif

endmodule
